// File: rtl/axilite_wr_arbiter.sv
// -----------------------------------------------------------------------------
// axilite_wr_arbiter
//
// Round-robin arbiter that lets NUM_REQ independent requesters share a single
// AXI4-Lite write-channel user port. At most one address/data word is forwarded
// per clock, and a granted requester may send up to MAX_BURST consecutive words
// before the grant is released and arbitration runs again.
//
// Ports:
//   clk            user write clock (same clock as the downstream user port)
//   reset          asynchronous, active-high reset
//   req_valid      per-requester request, held with addr/data until acked
//   req_addr       packed addresses, requester i at [i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH]
//   req_data       packed data, requester i at [i*USER_WR_DATA_WIDTH +: USER_WR_DATA_WIDTH]
//   req_ack        combinational, one-hot or zero: word accepted this cycle
//   user_wr_en     registered write strobe to the write channel
//   user_wr_addr   registered write address
//   user_wr_data   registered write data
//   user_wr_ready  downstream can accept a word
//   grant_id       requester currently owning the grant
//   busy           high while a grant is held
// -----------------------------------------------------------------------------
module axilite_wr_arbiter #(
  parameter int NUM_REQ            = 4,
  parameter int AXI_ADDR_WIDTH     = 32,
  parameter int USER_WR_DATA_WIDTH = 32,
  parameter int MAX_BURST          = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_REQ-1:0]                    req_valid,
  input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0]     req_addr,
  input  logic [NUM_REQ*USER_WR_DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]                    req_ack,
  output logic                                  user_wr_en,
  output logic [AXI_ADDR_WIDTH-1:0]             user_wr_addr,
  output logic [USER_WR_DATA_WIDTH-1:0]         user_wr_data,
  input  logic                                  user_wr_ready,
  output logic [$clog2(NUM_REQ)-1:0]            grant_id,
  output logic                                  busy
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int BC_W = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] grant_id_nxt;
  logic [ID_W-1:0] rr_ptr, rr_ptr_nxt;
  logic [BC_W-1:0] burst_cnt, burst_cnt_nxt;

  logic [ID_W-1:0]               winner;
  logic [ID_W-1:0]               search_idx;
  logic [ID_W-1:0]               ptr_after_grant;
  logic                          any_valid;
  logic                          granted_valid;
  logic                          ack_fire;
  logic                          last_word;
  logic [AXI_ADDR_WIDTH-1:0]     sel_addr;
  logic [USER_WR_DATA_WIDTH-1:0] sel_data;

  // Round-robin search starting at rr_ptr. The loop runs from the farthest
  // offset down to offset 0 so that the closest valid requester is the last
  // assignment and therefore wins, without needing an early exit.
  // NOTE: every variable driven in an always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    winner     = rr_ptr;
    search_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      search_idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (req_valid[search_idx]) begin
        winner = search_idx;
      end
    end
  end

  // Word mux for the granted requester, written with constant slice bounds.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        sel_addr = req_addr[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
        sel_data = req_data[i*USER_WR_DATA_WIDTH +: USER_WR_DATA_WIDTH];
      end
    end
  end

  assign any_valid       = |req_valid;
  assign granted_valid   = req_valid[grant_id];
  assign ack_fire        = (state == GRANT) && granted_valid && user_wr_ready;
  assign last_word       = (burst_cnt == BC_W'(MAX_BURST - 1));
  assign ptr_after_grant = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

  // Ack is gated by state, so it is zero in IDLE and during reset.
  assign req_ack = ack_fire ? (NUM_REQ'(1) << grant_id) : '0;
  assign busy    = (state == GRANT);

  // Next-state logic.
  always_comb begin
    state_nxt     = state;
    grant_id_nxt  = grant_id;
    rr_ptr_nxt    = rr_ptr;
    burst_cnt_nxt = burst_cnt;
    unique case (state)
      IDLE: begin
        if (any_valid) begin
          grant_id_nxt  = winner;
          burst_cnt_nxt = '0;
          state_nxt     = GRANT;
        end
      end
      GRANT: begin
        if (ack_fire) begin
          burst_cnt_nxt = burst_cnt + 1'b1;
        end
        // Release on a withdrawal or on the last word of the burst; the
        // releasing requester drops to lowest priority. Clearing the count
        // here keeps it below MAX_BURST at all times.
        if (!granted_valid || (ack_fire && last_word)) begin
          state_nxt     = IDLE;
          rr_ptr_nxt    = ptr_after_grant;
          burst_cnt_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      grant_id  <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      grant_id  <= grant_id_nxt;
      rr_ptr    <= rr_ptr_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

  // Registered user port: one-cycle latency from ack. Address and data hold
  // their last value between writes.
  // NOTE: the address/data registers are reset as well; they are ordinary
  // flops, not a memory array, and a known idle value is wanted downstream.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      user_wr_en   <= 1'b0;
      user_wr_addr <= '0;
      user_wr_data <= '0;
    end else begin
      user_wr_en <= ack_fire;
      if (ack_fire) begin
        user_wr_addr <= sel_addr;
        user_wr_data <= sel_data;
      end
    end
  end

endmodule
